spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- Sequences one SPI mode-0 transfer (CPOL=0, CPHA=0) of DATA_W bits per request.
- Gates the shared clk_div through spi_clk_en and takes the divided spi_clk back in, detecting its edges in the m_clk domain.
- Drives cs_n and mosi, samples miso, and returns the received word with a start/busy/done handshake to the host-side logic.
- Top level ties clk_div nrst to the inverse of rst.

Parameters:
- DATA_W, 8: bits per transfer, 2..32.
- CS_SETUP, 4: m_clk cycles from cs_n falling to spi_clk_en rising, 1..255.
- CS_HOLD, 4: m_clk cycles from spi_clk_en falling to cs_n rising, 1..255.
- MSB_FIRST, 1: 1 shifts MSB first; 0 shifts LSB first.

Ports:
- m_clk, in, 1: system clock. Also clocks clk_div.
- rst, in, 1: asynchronous reset, active-high.
- start, in, 1: transfer request. Sampled only in IDLE.
- tx_data, in, DATA_W: word to send. Captured on an accepted start.
- busy, out, 1: high from the cycle after start is accepted until the FSM returns to IDLE.
- done, out, 1: one-cycle pulse when the transfer completes.
- rx_data, out, DATA_W: received word. Valid from done and held until the next done.
- spi_clk, in, 1: divided clock from clk_div.
- spi_clk_en, out, 1: enable to clk_div.
- cs_n, out, 1: chip select, active-low.
- mosi, out, 1: serial data out.
- miso, in, 1: serial data in.

Behaviour:
- Reset values: busy=0, done=0, rx_data=0, spi_clk_en=0, cs_n=1, mosi=0. FSM goes to IDLE; shift registers and counters clear.
- Reset mid-transfer aborts at once; no done pulse is produced.
- Edge detect: spi_clk_d is spi_clk registered on m_clk. rise = spi_clk & ~spi_clk_d; fall = ~spi_clk & spi_clk_d. Reset value of spi_clk_d is 0.
- IDLE: on start=1, load tx_data into tx_sh, clear bit_cnt, set cs_n=0, drive mosi with the first bit, go to SETUP. Otherwise hold. start while not in IDLE is ignored.
- SETUP: count CS_SETUP cycles, then set spi_clk_en=1 and go to XFER.
- XFER:
  - On rise: shift miso into rx_sh in the configured bit order; bit_cnt++.
  - On fall with bit_cnt<DATA_W: shift tx_sh; mosi takes the next bit.
  - On fall with bit_cnt==DATA_W: set spi_clk_en=0 (spi_clk is then low and stays low) and go to HOLD. mosi holds its value.
- HOLD: count CS_HOLD cycles, then cs_n=1, rx_data<=rx_sh, done=1 for one cycle, return to IDLE.
- A start arriving in the same cycle as done is accepted.
- Timing with clk_div (toggle every 10 enabled cycles):
  - Nominal bit period is 20 m_clk.
  - The first half-period of a transfer may be shorter (1..10 cycles), because clk_div keeps its counter while disabled.
  - First rise comes within 10 cycles of spi_clk_en rising.
- Exactly DATA_W rising and DATA_W falling spi_clk edges occur per transfer.
- mosi changes only on fall or when leaving IDLE.
- bit_cnt width is clog2(DATA_W+1). A spurious rise once bit_cnt==DATA_W is ignored.
- spi_clk is never high when cs_n rises.

Decomposition:
- Package spi_pkg holds:
  - FSM state encoding: IDLE, SETUP, XFER, HOLD.
  - SPI mode constants.
  - The clk_div half-period constant (10), used by the bench.
- Sub-module spi_edge_det holds the spi_clk register and rise/fall outputs. The rest stays flat.

Test Plan:
- Single transfer, DATA_W=8, MSB_FIRST=1, tx_data=0xA5, miso looped to mosi:
  - rx_data=0xA5 at done.
  - 8 rises on spi_clk.
  - cs_n low ~4+160+4 (±10) m_clk.
  - busy high through the whole transfer.
- Fixed miso pattern, tx_data=0x3C, miso driven from 0x96 MSB first:
  - rx_data=0x96.
  - mosi bits sampled at rises read 0,0,1,1,1,1,0,0.
- LSB-first build (MSB_FIRST=0), tx_data=0x01:
  - mosi=1 at the first rise and 0 at the other 7.
- Back-to-back: start held high continuously:
  - Second transfer starts the cycle after done.
  - Each transfer gets exactly one done pulse.
  - spi_clk is low whenever cs_n=1.
- rst pulsed high mid-XFER (after the 3rd rise):
  - All outputs return to reset values asynchronously; no done pulse.
  - A following transfer of 0x5A completes correctly.
- start pulsed during SETUP and during XFER:
  - Ignored; rx_data and bit count are unaffected; only one done pulse.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master controller.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  // External clk_div toggles spi_clk after this many enabled m_clk cycles.
  localparam int unsigned CLK_DIV_HALF = 10;

endpackage

// File: rtl/spi_edge_det.sv
// Registers the divided spi_clk in the m_clk domain and flags its edges.
module spi_edge_det
  import spi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic spi_clk,
  output logic rise,
  output logic fall
);

  logic sclk_d;
  logic sclk_q;

  // Next value of the delayed spi_clk sample.
  always_comb begin
    sclk_d = spi_clk;
  end

  // Delayed spi_clk sample; idles at the mode-0 clock polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q <= SPI_CPOL;
    end else begin
      sclk_q <= sclk_d;
    end
  end

  assign rise = spi_clk & ~sclk_q;
  assign fall = ~spi_clk & sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one DATA_W-bit transfer per start, paced by an external
// clock divider that is gated through spi_clk_en.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CS_SETUP  = 4,
  parameter int unsigned CS_HOLD   = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              m_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  input  logic              spi_clk,
  output logic              spi_clk_en,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned      CNT_W      = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DATA_W);
  localparam logic [7:0]       SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0]       HOLD_LAST  = 8'(CS_HOLD - 1);

  spi_state_e        state_d, state_q;
  logic [DATA_W-1:0] tx_sh_d, tx_sh_q;
  logic [DATA_W-1:0] rx_sh_d, rx_sh_q;
  logic [DATA_W-1:0] rx_data_d, rx_data_q;
  logic [CNT_W-1:0]  bit_cnt_d, bit_cnt_q;
  logic [7:0]        tmr_d, tmr_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              spi_clk_en_d, spi_clk_en_q;
  logic              cs_n_d, cs_n_q;
  logic              mosi_d, mosi_q;
  logic              spi_rise;
  logic              spi_fall;

  spi_edge_det u_edge_det (
    .clk     (m_clk),
    .rst     (rst),
    .spi_clk (spi_clk),
    .rise    (spi_rise),
    .fall    (spi_fall)
  );

  // Transfer sequencing: next state and next value of every registered output.
  always_comb begin
    state_d      = state_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    rx_data_d    = rx_data_q;
    bit_cnt_d    = bit_cnt_q;
    tmr_d        = tmr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    spi_clk_en_d = spi_clk_en_q;
    cs_n_d       = cs_n_q;
    mosi_d       = mosi_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tx_sh_d   = tx_data;
          rx_sh_d   = '0;
          bit_cnt_d = '0;
          tmr_d     = 8'd0;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          mosi_d    = MSB_FIRST ? tx_data[DATA_W-1] : tx_data[0];
          state_d   = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tmr_q == SETUP_LAST) begin
          tmr_d        = 8'd0;
          spi_clk_en_d = 1'b1;
          state_d      = ST_XFER;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      ST_XFER: begin
        // Rises past the last bit are stray and must not disturb rx_sh.
        if (spi_rise && (bit_cnt_q < BIT_LAST)) begin
          rx_sh_d   = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], miso}
                                : {miso, rx_sh_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else if (spi_fall) begin
          if (bit_cnt_q < BIT_LAST) begin
            tx_sh_d = MSB_FIRST ? {tx_sh_q[DATA_W-2:0], 1'b0}
                                : {1'b0, tx_sh_q[DATA_W-1:1]};
            mosi_d  = MSB_FIRST ? tx_sh_q[DATA_W-2] : tx_sh_q[1];
          end else begin
            spi_clk_en_d = 1'b0;
            tmr_d        = 8'd0;
            state_d      = ST_HOLD;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          tmr_d     = 8'd0;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          state_d   = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, datapath and output registers.
  always_ff @(posedge m_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      rx_data_q    <= '0;
      bit_cnt_q    <= '0;
      tmr_q        <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      spi_clk_en_q <= 1'b0;
      cs_n_q       <= 1'b1;
      mosi_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      rx_data_q    <= rx_data_d;
      bit_cnt_q    <= bit_cnt_d;
      tmr_q        <= tmr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      spi_clk_en_q <= spi_clk_en_d;
      cs_n_q       <= cs_n_d;
      mosi_q       <= mosi_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rx_data    = rx_data_q;
  assign spi_clk_en = spi_clk_en_q;
  assign cs_n       = cs_n_q;
  assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: an MSB-first and an LSB-first instance,
// each paired with a behavioural clock divider.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  logic       m_clk = 1'b0;
  logic       rst;
  logic       div_nrst;
  logic       start_a, start_b;
  logic [7:0] tx_a, tx_b;
  logic       busy_a, done_a, en_a, cs_a, mosi_a, miso_a, spi_clk_a;
  logic       busy_b, done_b, en_b, cs_b, mosi_b, miso_b, spi_clk_b;
  logic [7:0] rx_a, rx_b;
  int         div_cnt_a, div_cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 m_clk = ~m_clk;
  assign div_nrst = ~rst;

  spi_master_ctrl #(.DATA_W(8), .CS_SETUP(4), .CS_HOLD(4), .MSB_FIRST(1'b1)) dut_a (
    .m_clk(m_clk), .rst(rst), .start(start_a), .tx_data(tx_a), .busy(busy_a),
    .done(done_a), .rx_data(rx_a), .spi_clk(spi_clk_a), .spi_clk_en(en_a),
    .cs_n(cs_a), .mosi(mosi_a), .miso(miso_a));

  spi_master_ctrl #(.DATA_W(8), .CS_SETUP(4), .CS_HOLD(4), .MSB_FIRST(1'b0)) dut_b (
    .m_clk(m_clk), .rst(rst), .start(start_b), .tx_data(tx_b), .busy(busy_b),
    .done(done_b), .rx_data(rx_b), .spi_clk(spi_clk_b), .spi_clk_en(en_b),
    .cs_n(cs_b), .mosi(mosi_b), .miso(miso_b));

  // Clock dividers: keep their count while disabled, toggle every CLK_DIV_HALF.
  always @(posedge m_clk or negedge div_nrst) begin
    if (!div_nrst) begin
      div_cnt_a <= 0;
      spi_clk_a <= 1'b0;
    end else if (en_a) begin
      if (div_cnt_a == int'(CLK_DIV_HALF) - 1) begin
        div_cnt_a <= 0;
        spi_clk_a <= ~spi_clk_a;
      end else begin
        div_cnt_a <= div_cnt_a + 1;
      end
    end
  end

  always @(posedge m_clk or negedge div_nrst) begin
    if (!div_nrst) begin
      div_cnt_b <= 0;
      spi_clk_b <= 1'b0;
    end else if (en_b) begin
      if (div_cnt_b == int'(CLK_DIV_HALF) - 1) begin
        div_cnt_b <= 0;
        spi_clk_b <= ~spi_clk_b;
      end else begin
        div_cnt_b <= div_cnt_b + 1;
      end
    end
  end

  // Monitors
  int         rise_a = 0, done_cnt_a = 0, cs_low_a = 0, clk_viol = 0, busy_viol = 0;
  int         rise_b = 0, done_cnt_b = 0;
  logic [7:0] mosi_rise_a = 8'h00, mosi_rise_b = 8'h00;
  logic       prev_a = 1'b0, prev_b = 1'b0;

  always @(posedge m_clk) begin
    prev_a <= spi_clk_a;
    prev_b <= spi_clk_b;
    if (spi_clk_a && !prev_a) begin
      rise_a      <= rise_a + 1;
      mosi_rise_a <= {mosi_rise_a[6:0], mosi_a};
    end
    if (spi_clk_b && !prev_b) begin
      rise_b      <= rise_b + 1;
      mosi_rise_b <= {mosi_rise_b[6:0], mosi_b};
    end
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (!cs_a) cs_low_a <= cs_low_a + 1;
    if ((cs_a && spi_clk_a) || (cs_b && spi_clk_b)) clk_viol <= clk_viol + 1;
    if (!cs_a && !busy_a) busy_viol <= busy_viol + 1;
  end

  // miso source for instance A: loopback or a fixed MSB-first pattern
  logic       pat_mode = 1'b0;
  logic [7:0] pat_val  = 8'h00;
  int         rise_base = 0;
  logic [2:0] pat_idx;
  assign pat_idx = 3'(rise_a - rise_base);
  assign miso_a  = pat_mode ? pat_val[3'd7 - pat_idx] : mosi_a;
  assign miso_b  = mosi_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge m_clk);
  endtask

  task automatic start_pulse_a(input logic [7:0] d);
    tx_a    = d;
    start_a = 1'b1;
    @(negedge m_clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge m_clk);
      if (done_a === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_rises_a(input int base, input int n, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge m_clk);
      if (rise_a - base >= n) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_rises_seen"}, 32'(seen), 32'd1);
  endtask

  int r0, d0, c0, clen;
  bit seen_b;

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; tx_a = 8'h00; tx_b = 8'h00;
    cyc(3);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_rx", 32'(rx_a), 32'h00);
    chk("rst_en", 32'(en_a), 32'd0);
    chk("rst_cs_n", 32'(cs_a), 32'd1);
    chk("rst_mosi", 32'(mosi_a), 32'd0);
    rst = 1'b0;
    cyc(2);

    // Loopback transfer of 0xA5
    r0 = rise_a; d0 = done_cnt_a; c0 = cs_low_a;
    start_pulse_a(8'hA5);
    chk("a5_busy_after_start", 32'(busy_a), 32'd1);
    chk("a5_cs_low", 32'(cs_a), 32'd0);
    wait_done_a("a5");
    chk("a5_rx", 32'(rx_a), 32'hA5);
    chk("a5_rises", 32'(rise_a - r0), 32'd8);
    chk("a5_mosi_bits", 32'(mosi_rise_a), 32'hA5);
    clen = cs_low_a - c0;
    chk("a5_cs_len_in_158_178", 32'(clen >= 158 && clen <= 178), 32'd1);
    chk("a5_busy_viol", 32'(busy_viol), 32'd0);
    cyc(3);
    chk("a5_one_done", 32'(done_cnt_a - d0), 32'd1);
    chk("a5_idle_busy", 32'(busy_a), 32'd0);

    // Fixed miso pattern 0x96, tx 0x3C
    pat_mode = 1'b1; pat_val = 8'h96; rise_base = rise_a; r0 = rise_a;
    start_pulse_a(8'h3C);
    wait_done_a("pat");
    chk("pat_rx", 32'(rx_a), 32'h96);
    chk("pat_mosi_bits", 32'(mosi_rise_a), 32'h3C);
    chk("pat_rises", 32'(rise_a - r0), 32'd8);
    pat_mode = 1'b0;
    cyc(2);

    // LSB-first instance, tx 0x01, loopback
    tx_b = 8'h01; start_b = 1'b1;
    @(negedge m_clk);
    start_b = 1'b0; r0 = rise_b; seen_b = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge m_clk);
      if (done_b === 1'b1) begin
        seen_b = 1'b1;
        break;
      end
    end
    chk("lsb_done_seen", 32'(seen_b), 32'd1);
    chk("lsb_rx", 32'(rx_b), 32'h01);
    chk("lsb_mosi_first_only", 32'(mosi_rise_b), 32'h80);
    chk("lsb_rises", 32'(rise_b - r0), 32'd8);
    cyc(2);
    chk("lsb_cs_idle", 32'(cs_b), 32'd1);
    chk("lsb_busy_idle", 32'(busy_b), 32'd0);
    chk("lsb_one_done", 32'(done_cnt_b), 32'd1);

    // Back-to-back with start held high
    d0 = done_cnt_a;
    tx_a = 8'h81; start_a = 1'b1;
    wait_done_a("b2b_first");
    chk("b2b_first_rx", 32'(rx_a), 32'h81);
    @(negedge m_clk);
    chk("b2b_restart_cs", 32'(cs_a), 32'd0);
    chk("b2b_restart_busy", 32'(busy_a), 32'd1);
    wait_done_a("b2b_second");
    start_a = 1'b0;
    chk("b2b_second_rx", 32'(rx_a), 32'h81);
    cyc(3);
    chk("b2b_no_third", 32'(cs_a), 32'd1);
    chk("b2b_two_dones", 32'(done_cnt_a - d0), 32'd2);
    chk("b2b_clk_low_when_cs_high", 32'(clk_viol), 32'd0);

    // Reset after the third rise of a transfer
    d0 = done_cnt_a; r0 = rise_a;
    start_pulse_a(8'hFF);
    wait_rises_a(r0, 3, "abort");
    #2 rst = 1'b1;
    #1;
    chk("abort_cs_n", 32'(cs_a), 32'd1);
    chk("abort_en", 32'(en_a), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_mosi", 32'(mosi_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_rx", 32'(rx_a), 32'h00);
    cyc(2);
    rst = 1'b0;
    cyc(5);
    chk("abort_no_done", 32'(done_cnt_a - d0), 32'd0);
    r0 = rise_a;
    start_pulse_a(8'h5A);
    wait_done_a("post_abort");
    chk("post_abort_rx", 32'(rx_a), 32'h5A);
    chk("post_abort_rises", 32'(rise_a - r0), 32'd8);
    cyc(2);

    // Stray start pulses during SETUP and XFER are ignored
    pat_mode = 1'b1; pat_val = 8'h96; rise_base = rise_a; r0 = rise_a; d0 = done_cnt_a;
    start_pulse_a(8'hC3);
    tx_a = 8'hFF; start_a = 1'b1;
    @(negedge m_clk);
    start_a = 1'b0;
    wait_rises_a(r0, 4, "ign");
    start_a = 1'b1;
    @(negedge m_clk);
    start_a = 1'b0;
    wait_done_a("ign");
    chk("ign_rx", 32'(rx_a), 32'h96);
    chk("ign_mosi_bits", 32'(mosi_rise_a), 32'hC3);
    chk("ign_rises", 32'(rise_a - r0), 32'd8);
    cyc(30);
    chk("ign_one_done", 32'(done_cnt_a - d0), 32'd1);
    chk("ign_cs_idle", 32'(cs_a), 32'd1);
    chk("ign_clk_viol", 32'(clk_viol), 32'd0);
    chk("ign_busy_viol", 32'(busy_viol), 32'd0);
    pat_mode = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
